neuron_train_sequencer: RTL and testbench

Training-run controller for a `neuron_learn` layer: it sequences sample fetch, settle and learn strobes for a configurable number of epochs.
- Fetches each training sample from an external sample store via a req/ack handshake.
- Holds the layer's `valid` high while the combinational forward and backward paths settle, then issues a single-cycle `learn` strobe.
- Sits between the top-level host or testbench control and the `valid`/`learn` inputs shared by every neuron in a layer.

---
 rtl/neuron_train_sequencer.sv | 177 +++++++++++++++++
 tb/tb_neuron_train_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_train_sequencer.sv
// Training-run sequencer for a neuron_learn layer: fetch, settle and learn per sample, per epoch.
// Optional evaluation pass after each epoch when NEURON_TRAIN_SEQ_EVAL_PASS_EN is defined.
module neuron_train_sequencer #(
  parameter int unsigned NUM_SAMPLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned EPOCH_W       = 8,
  parameter int unsigned IDX_W         = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [EPOCH_W-1:0] num_epochs,
  output logic               sample_req,
  input  logic               sample_ack,
  output logic [IDX_W-1:0]   sample_idx,
  output logic               layer_valid,
  output logic               layer_learn,
  output logic               busy,
  output logic               done,
  output logic               aborted,
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
  output logic               eval_phase,
`endif
  output logic [EPOCH_W-1:0] epoch_count
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StSettle = 3'd2,
    StLearn  = 3'd3,
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
    StEval   = 3'd5,
`endif
    StFinish = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [EPOCH_W-1:0] epochs_q, epochs_d;
  logic [EPOCH_W-1:0] epoch_d, epoch_inc;
  logic [IDX_W-1:0]   idx_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               aborted_d;
  logic               valid_d;
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
  logic               eval_q, eval_d;
`endif

  assign epoch_inc = (epoch_count == {EPOCH_W{1'b1}}) ? epoch_count : epoch_count + 1'b1;

  always_comb begin
    state_d   = state_q;
    epochs_d  = epochs_q;
    epoch_d   = epoch_count;
    idx_d     = sample_idx;
    cnt_d     = cnt_q;
    aborted_d = 1'b0;
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
    eval_d    = eval_q;
`endif
    if (state_q != StIdle && abort) begin
      // Abort freezes counters, including a LEARN cycle already on the wire.
      state_d   = StIdle;
      aborted_d = 1'b1;
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
      eval_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            epochs_d = num_epochs;
            epoch_d  = '0;
            idx_d    = '0;
            state_d  = (num_epochs == '0) ? StFinish : StFetch;
          end
        end
        StFetch: begin
          if (sample_ack) begin
            cnt_d   = SettleLast;
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
            state_d = eval_q ? StEval : StSettle;
`else
            state_d = StSettle;
`endif
          end
        end
        StSettle: begin
          if (cnt_q == '0) state_d = StLearn;
          else             cnt_d   = cnt_q - 1'b1;
        end
        StLearn: begin
          state_d = StFetch;
          if (sample_idx != LastIdx) begin
            idx_d = sample_idx + 1'b1;
          end else begin
            idx_d = '0;
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
            eval_d = 1'b1;
`else
            epoch_d = epoch_inc;
            if (epoch_inc == epochs_q) state_d = StFinish;
`endif
          end
        end
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
        StEval: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = StFetch;
            if (sample_idx != LastIdx) begin
              idx_d = sample_idx + 1'b1;
            end else begin
              idx_d   = '0;
              eval_d  = 1'b0;
              epoch_d = epoch_inc;
              if (epoch_inc == epochs_q) state_d = StFinish;
            end
          end
        end
`endif
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
  assign valid_d = (state_d == StSettle) || (state_d == StLearn) || (state_d == StEval);
`else
  assign valid_d = (state_d == StSettle) || (state_d == StLearn);
`endif

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      epochs_q    <= '0;
      epoch_count <= '0;
      sample_idx  <= '0;
      cnt_q       <= '0;
      sample_req  <= 1'b0;
      layer_valid <= 1'b0;
      layer_learn <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
      eval_q      <= 1'b0;
      eval_phase  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      epochs_q    <= epochs_d;
      epoch_count <= epoch_d;
      sample_idx  <= idx_d;
      cnt_q       <= cnt_d;
      sample_req  <= (state_d == StFetch);
      layer_valid <= valid_d;
      layer_learn <= (state_d == StLearn);
      busy        <= (state_d != StIdle);
      done        <= (state_d == StFinish);
      aborted     <= aborted_d;
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
      eval_q      <= eval_d;
      eval_phase  <= eval_d;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Directed self-checking bench for neuron_train_sequencer (NUM_SAMPLES=4, SETTLE_CYCLES=2).
module tb_neuron_train_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned SC = 2;
  localparam int unsigned EW = 8;

  logic          clock = 1'b0;
  logic          reset, start, abort, sample_ack;
  logic [EW-1:0] num_epochs;
  logic          sample_req, layer_valid, layer_learn, busy, done, aborted;
  logic [1:0]    sample_idx;
  logic [EW-1:0] epoch_count;
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
  logic          eval_phase;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  neuron_train_sequencer #(
    .NUM_SAMPLES  (NS),
    .SETTLE_CYCLES(SC),
    .EPOCH_W      (EW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .num_epochs (num_epochs),
    .sample_req (sample_req),
    .sample_ack (sample_ack),
    .sample_idx (sample_idx),
    .layer_valid(layer_valid),
    .layer_learn(layer_learn),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
    .eval_phase (eval_phase),
`endif
    .epoch_count(epoch_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // {req, valid, learn, done, busy}
  function automatic logic [4:0] sigs();
    return {sample_req, layer_valid, layer_learn, done, busy};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; sample_ack = 1'b0; num_epochs = '0;
    step(); step();
    reset = 1'b0;
    step();
    n_cmp++;
    if ({sigs(), aborted} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 000000", {sigs(), aborted});
    end
    n_cmp++;
    if (sample_idx !== 2'd0) begin
      n_bad++; $display("FAIL reset_idx got %0d want 0", sample_idx);
    end
    n_cmp++;
    if (epoch_count !== 8'd0) begin
      n_bad++; $display("FAIL reset_epoch got %0d want 0", epoch_count);
    end
  endtask

  task automatic test_two_epochs();
    logic [4:0] exp_s;
    logic [1:0] exp_idx;
    sample_ack = 1'b1; num_epochs = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 4; p++) begin
        exp_s   = (p == 0) ? 5'b10001 : (p == 3) ? 5'b01101 : 5'b01001;
        exp_idx = k[1:0];
        n_cmp++;
        if (sigs() !== exp_s) begin
          n_bad++; $display("FAIL two_epochs_sigs k=%0d p=%0d got %b want %b", k, p, sigs(), exp_s);
        end
        n_cmp++;
        if (sample_idx !== exp_idx) begin
          n_bad++; $display("FAIL two_epochs_idx k=%0d got %0d want %0d", k, sample_idx, exp_idx);
        end
        n_cmp++;
        if (epoch_count !== 8'(k / 4)) begin
          n_bad++; $display("FAIL two_epochs_epoch k=%0d got %0d want %0d", k, epoch_count, k / 4);
        end
        step();
      end
    end
    n_cmp++;
    if (sigs() !== 5'b00011) begin
      n_bad++; $display("FAIL two_epochs_finish got %b want 00011", sigs());
    end
    n_cmp++;
    if (epoch_count !== 8'd2) begin
      n_bad++; $display("FAIL two_epochs_count got %0d want 2", epoch_count);
    end
    step();
    n_cmp++;
    if ({sigs(), epoch_count} !== {5'b00000, 8'd2}) begin
      n_bad++; $display("FAIL two_epochs_idle got %b/%0d want 00000/2", sigs(), epoch_count);
    end
  endtask

  task automatic test_zero_epochs();
    sample_ack = 1'b0; num_epochs = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (sigs() !== 5'b00011) begin
      n_bad++; $display("FAIL zero_epochs_done got %b want 00011", sigs());
    end
    n_cmp++;
    if (epoch_count !== 8'd0) begin
      n_bad++; $display("FAIL zero_epochs_count got %0d want 0", epoch_count);
    end
    step();
    n_cmp++;
    if (sigs() !== 5'b00000) begin
      n_bad++; $display("FAIL zero_epochs_idle got %b want 00000", sigs());
    end
  endtask

  task automatic test_delayed_ack();
    logic seen;
    sample_ack = 1'b1; num_epochs = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (layer_learn !== 1'b1) begin
      n_bad++; $display("FAIL delay_first_learn got %b want 1", layer_learn);
    end
    sample_ack = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({sample_req, layer_valid, sample_idx} !== {1'b1, 1'b0, 2'd1}) begin
        n_bad++;
        $display("FAIL delay_fetch i=%0d got req=%b valid=%b idx=%0d want 1 0 1",
                 i, sample_req, layer_valid, sample_idx);
      end
      if (i == 5) sample_ack = 1'b1;
      step();
    end
    n_cmp++;
    if ({sample_req, layer_valid} !== 2'b01) begin
      n_bad++; $display("FAIL delay_settle got %b want 01", {sample_req, layer_valid});
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1 || epoch_count !== 8'd1) begin
      n_bad++; $display("FAIL delay_done got seen=%b epoch=%0d want 1 1", seen, epoch_count);
    end
    step();
  endtask

  task automatic test_abort();
    logic seen;
    sample_ack = 1'b1; num_epochs = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 26; i++) step();
    n_cmp++;
    if ({sigs(), sample_idx, epoch_count} !== {5'b01001, 2'd2, 8'd1}) begin
      n_bad++; $display("FAIL abort_pre got %b/%0d/%0d want 01001/2/1", sigs(), sample_idx, epoch_count);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({sigs(), aborted} !== 6'b000001) begin
      n_bad++; $display("FAIL abort_edge got %b want 000001", {sigs(), aborted});
    end
    n_cmp++;
    if (epoch_count !== 8'd1) begin
      n_bad++; $display("FAIL abort_epoch got %0d want 1", epoch_count);
    end
    step();
    n_cmp++;
    if ({done, aborted, busy} !== 3'b000) begin
      n_bad++; $display("FAIL abort_after got %b want 000", {done, aborted, busy});
    end
    // abort alone in IDLE is ignored; with start the start wins
    abort = 1'b1;
    step();
    n_cmp++;
    if ({aborted, busy} !== 2'b00) begin
      n_bad++; $display("FAIL abort_idle got %b want 00", {aborted, busy});
    end
    num_epochs = 8'd1; start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if ({sample_req, busy, aborted, sample_idx, epoch_count} !== {3'b110, 2'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL restart got req=%b busy=%b ab=%b idx=%0d ep=%0d want 1 1 0 0 0",
               sample_req, busy, aborted, sample_idx, epoch_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1 || epoch_count !== 8'd1) begin
      n_bad++; $display("FAIL restart_done got seen=%b epoch=%0d want 1 1", seen, epoch_count);
    end
    step();
  endtask

  task automatic test_abort_in_learn();
    sample_ack = 1'b1; num_epochs = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if ({layer_learn, sample_idx} !== {1'b1, 2'd3}) begin
      n_bad++; $display("FAIL learn_abort_pre got learn=%b idx=%0d want 1 3", layer_learn, sample_idx);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({layer_learn, aborted, done, busy, epoch_count, sample_idx} !== {4'b0100, 8'd0, 2'd3}) begin
      n_bad++;
      $display("FAIL learn_abort got learn=%b ab=%b done=%b busy=%b ep=%0d idx=%0d want 0 1 0 0 0 3",
               layer_learn, aborted, done, busy, epoch_count, sample_idx);
    end
    step();
  endtask

  task automatic test_start_while_busy();
    logic [4:0] exp_s;
    logic [1:0] exp_idx;
    sample_ack = 1'b1; num_epochs = 8'd1; start = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        start      = (p == 1);
        num_epochs = 8'd5;
        exp_s      = (p == 0) ? 5'b10001 : (p == 3) ? 5'b01101 : 5'b01001;
        exp_idx    = k[1:0];
        n_cmp++;
        if ({sigs(), sample_idx} !== {exp_s, exp_idx}) begin
          n_bad++;
          $display("FAIL busy_start k=%0d p=%0d got %b/%0d want %b/%0d",
                   k, p, sigs(), sample_idx, exp_s, exp_idx);
        end
        step();
      end
    end
    start = 1'b0;
    n_cmp++;
    if ({sigs(), epoch_count} !== {5'b00011, 8'd1}) begin
      n_bad++; $display("FAIL busy_start_done got %b/%0d want 00011/1", sigs(), epoch_count);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    sample_ack = 1'b1; num_epochs = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({sigs(), aborted, epoch_count, sample_idx} !== {6'b0, 8'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_mid got %b/%0d/%0d want 000000/0/0",
               {sigs(), aborted}, epoch_count, sample_idx);
    end
    step();
  endtask

`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
  task automatic test_eval_pass();
    logic [5:0] exp_s;
    sample_ack = 1'b1; num_epochs = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    // {eval, req, valid, learn, done, busy}
    for (int k = 0; k < 2 * NS; k++) begin
      for (int p = 0; p < ((k < NS) ? 4 : 3); p++) begin
        if (k < NS) exp_s = (p == 0) ? 6'b010001 : (p == 3) ? 6'b001101 : 6'b001001;
        else        exp_s = (p == 0) ? 6'b110001 : 6'b101001;
        n_cmp++;
        if ({eval_phase, sigs()} !== exp_s || epoch_count !== 8'd0) begin
          n_bad++;
          $display("FAIL eval_seq k=%0d p=%0d got %b/%0d want %b/0",
                   k, p, {eval_phase, sigs()}, epoch_count, exp_s);
        end
        step();
      end
    end
    n_cmp++;
    if ({eval_phase, sigs(), epoch_count} !== {6'b000011, 8'd1}) begin
      n_bad++; $display("FAIL eval_done got %b/%0d want 000011/1", {eval_phase, sigs()}, epoch_count);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
`ifdef NEURON_TRAIN_SEQ_EVAL_PASS_EN
    test_eval_pass();
`else
    test_two_epochs();
    test_zero_epochs();
    test_delayed_ack();
    test_abort();
    test_abort_in_learn();
    test_start_while_busy();
    test_reset_midrun();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
